// File: rtl/nios_dbg_cmd_sync_if.sv
// Command-path signals between the JTAG update logic and the OCI consumer.
// slave = debug-command synchroniser, master = its environment.
interface nios_dbg_cmd_sync_if #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int FIFO_DEPTH = 4
);
    logic                              udr_tgl;
    logic                              uir_tgl;
    logic [IR_WIDTH-1:0]               ir_in;
    logic [DR_WIDTH-1:0]               sr;
    logic                              cmd_ready;
    logic                              ovf_clr;
    logic                              cmd_valid;
    logic [IR_WIDTH-1:0]               cmd_ir;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   cmd_level;
    logic [DR_WIDTH-1:0]               jdo;
    logic [IR_WIDTH-1:0]               jdo_ir;
    logic [(2**IR_WIDTH)-1:0]          take_action;
    logic [(2**IR_WIDTH)-1:0]          take_no_action;
    logic                              uir_pulse;
    logic                              overflow;

    modport slave (
        input  udr_tgl, uir_tgl, ir_in, sr, cmd_ready, ovf_clr,
        output cmd_valid, cmd_ir, cmd_level, jdo, jdo_ir,
               take_action, take_no_action, uir_pulse, overflow
    );

    modport master (
        output udr_tgl, uir_tgl, ir_in, sr, cmd_ready, ovf_clr,
        input  cmd_valid, cmd_ir, cmd_level, jdo, jdo_ir,
               take_action, take_no_action, uir_pulse, overflow
    );
endinterface

// File: rtl/nios_dbg_cmd_sync.sv
// Brings tck-domain update-DR/IR toggles into clk, queues {IR, DR} commands in a
// FWFT FIFO and presents the popped word on jdo with one-hot action strobes.
module nios_dbg_cmd_sync #(
    parameter int DR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACTION_BIT  = 37
) (
    input  logic                 clk,
    input  logic                 reset,
    nios_dbg_cmd_sync_if.slave   bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int LANES   = 2 ** IR_WIDTH;
    localparam int ENTRY_W = IR_WIDTH + DR_WIDTH;
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] udr_sync_reg;
    logic [SYNC_STAGES-1:0] uir_sync_reg;
    logic                   udr_q_reg;
    logic                   uir_q_reg;
    logic                   udr_edge_reg;
    logic                   uir_edge_reg;
    logic                   uir_pulse_reg;
    logic [ARM_W-1:0]       arm_cnt_reg;
    logic                   armed;
    logic                   udr_sync_out;
    logic                   uir_sync_out;

    assign udr_sync_out = udr_sync_reg[SYNC_STAGES-1];
    assign uir_sync_out = uir_sync_reg[SYNC_STAGES-1];
    assign armed        = (arm_cnt_reg == ARM_W'(ARM_MAX));

    // Edges stay masked until the chains have flushed the level present at
    // reset release, so a toggle sitting at 1 through reset never fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_reg  <= '0;
            uir_sync_reg  <= '0;
            udr_q_reg     <= 1'b0;
            uir_q_reg     <= 1'b0;
            udr_edge_reg  <= 1'b0;
            uir_edge_reg  <= 1'b0;
            uir_pulse_reg <= 1'b0;
            arm_cnt_reg   <= '0;
        end else begin
            udr_sync_reg  <= {udr_sync_reg[SYNC_STAGES-2:0], bus.udr_tgl};
            uir_sync_reg  <= {uir_sync_reg[SYNC_STAGES-2:0], bus.uir_tgl};
            udr_q_reg     <= udr_sync_out;
            uir_q_reg     <= uir_sync_out;
            udr_edge_reg  <= armed & (udr_sync_out ^ udr_q_reg);
            uir_edge_reg  <= armed & (uir_sync_out ^ uir_q_reg);
            uir_pulse_reg <= uir_edge_reg;
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
            end
        end
    end

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_reg;
    logic [PTR_W:0]      rd_ptr_reg;
    logic [PTR_W:0]      level;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                wr_en;
    logic [ENTRY_W-1:0]  head;
    logic [IR_WIDTH-1:0] head_ir;
    logic [DR_WIDTH-1:0] head_dr;
    logic [LANES-1:0]    lane_hit;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (level == '0);
    assign full    = (level == (PTR_W+1)'(FIFO_DEPTH));
    assign push    = udr_edge_reg;
    assign pop     = !empty && bus.cmd_ready;
    assign wr_en   = push && (!full || pop);
    assign head    = mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_ir = head[ENTRY_W-1 -: IR_WIDTH];
    assign head_dr = head[DR_WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_hit[gi] = (head_ir == IR_WIDTH'(gi));
        end
    endgenerate

    // Storage is not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= {bus.ir_in, bus.sr};
        end
    end

    logic [DR_WIDTH-1:0] jdo_reg;
    logic [IR_WIDTH-1:0] jdo_ir_reg;
    logic [LANES-1:0]    take_action_reg;
    logic [LANES-1:0]    take_no_action_reg;
    logic                overflow_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            jdo_reg            <= '0;
            jdo_ir_reg         <= '0;
            take_action_reg    <= '0;
            take_no_action_reg <= '0;
            overflow_reg       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            end
            take_action_reg    <= '0;
            take_no_action_reg <= '0;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
                jdo_reg    <= head_dr;
                jdo_ir_reg <= head_ir;
                if (head_dr[ACTION_BIT]) begin
                    take_action_reg <= lane_hit;
                end else begin
                    take_no_action_reg <= lane_hit;
                end
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign bus.cmd_valid      = !empty;
    assign bus.cmd_ir         = empty ? '0 : head_ir;
    assign bus.cmd_level      = LVL_W'(level);
    assign bus.jdo            = jdo_reg;
    assign bus.jdo_ir         = jdo_ir_reg;
    assign bus.take_action    = take_action_reg;
    assign bus.take_no_action = take_no_action_reg;
    assign bus.uir_pulse      = uir_pulse_reg;
    assign bus.overflow       = overflow_reg;
endmodule

// File: tb/tb_nios_dbg_cmd_sync.sv
// Directed bench for nios_dbg_cmd_sync: arming, latency, overflow, full-FIFO
// push/pop, strobe lanes, simultaneous IR/DR updates and async reset.
module tb_nios_dbg_cmd_sync;
    localparam int DRW = 38;
    localparam int IRW = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic seen;

    always #5 clk = ~clk;

    nios_dbg_cmd_sync_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .FIFO_DEPTH(4)) bus ();

    nios_dbg_cmd_sync #(
        .DR_WIDTH(DRW), .IR_WIDTH(IRW), .SYNC_STAGES(2), .FIFO_DEPTH(4), .ACTION_BIT(37)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flip_udr(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr);
        bus.ir_in   = ir;
        bus.sr      = dr;
        bus.udr_tgl = ~bus.udr_tgl;
        $display("push ir=%0d sr=%h", ir, dr);
    endtask

    initial begin
        reset         = 1'b1;
        bus.udr_tgl   = 1'b1;
        bus.uir_tgl   = 1'b0;
        bus.ir_in     = '0;
        bus.sr        = '0;
        bus.cmd_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick(2);
        chk("rst_valid", bus.cmd_valid, 0);
        chk("rst_jdo", bus.jdo, 0);
        chk("rst_strobes", {bus.take_action, bus.take_no_action}, 0);
        chk("rst_ovf", bus.overflow, 0);

        // Toggle held at 1 across reset release must not create a command.
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.cmd_valid || bus.uir_pulse) seen = 1'b1;
        end
        chk("arm_noval", seen, 0);
        chk("arm_ovf", bus.overflow, 0);
        chk("arm_level", bus.cmd_level, 0);

        // Latency and take_action lane 2.
        flip_udr(2'd2, 38'h20_0000_00A5);
        tick(3);
        chk("lat_early", bus.cmd_valid, 0);
        tick(1);
        chk("lat_valid", bus.cmd_valid, 1);
        chk("lat_ir", bus.cmd_ir, 2);
        chk("lat_level", bus.cmd_level, 1);
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        $display("pop jdo=%h ir=%0d", bus.jdo, bus.jdo_ir);
        chk("pop_jdo", bus.jdo, 38'h20_0000_00A5);
        chk("pop_act", bus.take_action, 4'b0100);
        chk("pop_noact", bus.take_no_action, 0);
        chk("pop_empty", bus.cmd_valid, 0);
        tick(1);
        chk("strobe_1clk", bus.take_action, 0);
        chk("jdo_hold", bus.jdo, 38'h20_0000_00A5);

        // Five pushes into a four-entry FIFO with no consumer.
        for (int i = 1; i <= 5; i++) begin
            flip_udr(2'd0, DRW'(i));
            tick(6);
        end
        chk("ovf_level", bus.cmd_level, 4);
        chk("ovf_set", bus.overflow, 1);
        bus.cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            $display("pop jdo=%h ir=%0d", bus.jdo, bus.jdo_ir);
            chk("drain_jdo", bus.jdo, i);
            chk("drain_noact", bus.take_no_action, 4'b0001);
        end
        bus.cmd_ready = 1'b0;
        chk("drain_empty", bus.cmd_valid, 0);
        chk("ovf_sticky", bus.overflow, 1);
        bus.ovf_clr = 1'b1;
        tick(1);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 0);

        // Full FIFO: pop coinciding with a push keeps level and order.
        for (int i = 11; i <= 14; i++) begin
            flip_udr(2'd0, DRW'(i));
            tick(6);
        end
        chk("full_level", bus.cmd_level, 4);
        flip_udr(2'd0, DRW'(15));
        tick(3);
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        chk("pp_level", bus.cmd_level, 4);
        chk("pp_ovf", bus.overflow, 0);
        chk("pp_jdo", bus.jdo, 11);
        bus.cmd_ready = 1'b1;
        for (int i = 12; i <= 15; i++) begin
            tick(1);
            $display("pop jdo=%h ir=%0d", bus.jdo, bus.jdo_ir);
            chk("pp_order", bus.jdo, i);
        end
        bus.cmd_ready = 1'b0;
        chk("pp_empty", bus.cmd_level, 0);

        // take_no_action on lane 1.
        flip_udr(2'd1, 38'h00_0000_0077);
        tick(4);
        chk("na_ir", bus.cmd_ir, 1);
        bus.cmd_ready = 1'b1;
        tick(1);
        bus.cmd_ready = 1'b0;
        chk("na_noact", bus.take_no_action, 4'b0010);
        chk("na_act", bus.take_action, 0);
        chk("na_jdo_ir", bus.jdo_ir, 1);

        // Simultaneous IR and DR updates.
        bus.uir_tgl = ~bus.uir_tgl;
        flip_udr(2'd3, 38'h20_0000_0003);
        tick(3);
        chk("uir_early", bus.uir_pulse, 0);
        tick(1);
        chk("uir_pulse", bus.uir_pulse, 1);
        chk("uir_push", bus.cmd_valid, 1);
        chk("uir_level", bus.cmd_level, 1);
        tick(1);
        chk("uir_1clk", bus.uir_pulse, 0);
        tick(2);
        flip_udr(2'd3, 38'h20_0000_0033);
        tick(6);
        chk("mid_level", bus.cmd_level, 2);

        // Async reset mid-drain.
        bus.cmd_ready = 1'b1;
        tick(1);
        chk("mid_act", bus.take_action, 4'b1000);
        chk("mid_jdo", bus.jdo, 38'h20_0000_0003);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", bus.cmd_valid, 0);
        chk("ar_strobes", {bus.take_action, bus.take_no_action}, 0);
        chk("ar_level", bus.cmd_level, 0);
        chk("ar_jdo", bus.jdo, 0);
        bus.cmd_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
